sub8se_stream: RTL



---
 rtl/sub8se_pkg.sv | 23 ++
 rtl/sub8se_core.sv | 18 +
 rtl/sub8se_stream.sv | 98 +++++++++
 3 files changed

// File: rtl/sub8se_pkg.sv
// Shared types and arithmetic helpers for the 8-bit signed approximate subtractor family.
package sub8se_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [RES_W-1:0] diff_t;

  function automatic diff_t diff_exact(input operand_t a, input operand_t b);
    diff_t w_sa;
    diff_t w_sb;
    w_sa = {a[OP_W-1], a};
    w_sb = {b[OP_W-1], b};
    return w_sa - w_sb;
  endfunction

  // Borrow chain stays exact; only bit 0 swaps XOR for OR, so the error is +1 when both LSBs are set.
  function automatic diff_t diff_approx(input operand_t a, input operand_t b);
    diff_t w_e;
    w_e = diff_exact(a, b);
    return {w_e[RES_W-1:1], a[0] | b[0]};
  endfunction
endpackage

// File: rtl/sub8se_core.sv
// Purely combinational 8-bit signed subtractor; APPROX selects the cheap-LSB variant.
module sub8se_core
  import sub8se_pkg::*;
#(
  parameter int APPROX = 1
) (
  input  operand_t i_a,
  input  operand_t i_b,
  output diff_t    o_d
);
  generate
    if (APPROX != 0) begin : g_approx
      assign o_d = diff_approx(i_a, i_b);
    end else begin : g_exact
      assign o_d = diff_exact(i_a, i_b);
    end
  endgenerate
endmodule

// File: rtl/sub8se_stream.sv
// Two-stage elastic streaming subtractor (operands in S1, result in S2).
// Optional error-statistics counters are built when SUB8SE_STATS_EN is defined.
module sub8se_stream
  import sub8se_pkg::*;
#(
  parameter int APPROX = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_d
`ifdef SUB8SE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  // Handshake: a word moves across a port on any rising edge where valid & ready are both 1;
  // valid never depends on ready, and out_d is held while out_valid & ~out_ready.
  logic     r_s1_valid;
  operand_t r_s1_a;
  operand_t r_s1_b;
  logic     r_s2_valid;
  diff_t    r_s2_d;
  logic     w_s2_load;
  diff_t    w_diff;

  sub8se_core #(.APPROX(APPROX)) u_core (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_d (w_diff)
  );

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign out_valid = r_s2_valid;
  assign out_d     = r_s2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_d     <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_d <= w_diff;
      end
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a <= in_a;
          r_s1_b <= in_b;
        end
      end
    end
  end

`ifdef SUB8SE_STATS_EN
  logic             r_s2_err;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_out_fire;
  logic             w_s1_err;

  // Exact compare travels with the result so the counters see the error of the word delivered.
  assign w_s1_err   = (w_diff != diff_exact(r_s1_a, r_s1_b));
  assign w_out_fire = r_s2_valid & out_ready;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_err     <= 1'b0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_s2_load && r_s1_valid) r_s2_err <= w_s1_err;
      if (stats_clr) begin
        r_sample_cnt <= '0;
        r_err_cnt    <= '0;
      end else if (w_out_fire) begin
        if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
        if (r_s2_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end
`endif
endmodule
